// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: pipelined IEEE-754 multiplier, generic exponent/fraction width.
// Flush-to-zero on subnormal inputs and outputs, round-to-nearest-even,
// canonical quiet NaN on invalid operations.
//
// Pipeline: input register -> S1 unpack/classify/exponent -> S2 significand
// product -> S3 normalise/round/pack into the output register.
// A single enable stalls every stage, so backpressure never drops data.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_valid, o_ready   operand handshake (o_ready is combinational)
//   i_a, i_b           operands, DW bits
//   o_valid, i_ready   result handshake
//   o_m                product, DW bits
//   o_flags            {invalid, overflow, underflow, inexact}, aligned with o_m
module fpu_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DW = 1 + EXP_W + MAN_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_m,
    output logic [3:0]    o_flags
);

    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * (MAN_W + 1);
    localparam logic signed [EW2-1:0] BIAS   = EW2'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EMAX   = EW2'((2 ** EXP_W) - 1);
    localparam logic signed [EW2-1:0] ONE_E  = EW2'(1);
    localparam logic signed [EW2-1:0] ZERO_E = '0;

    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // input register
    logic          v0;
    logic [DW-1:0] a0, b0;

    // S1 classification (combinational from input register)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic c_nan, c_inf, c_zero;
    logic signed [EW2-1:0] e_sum;

    assign ea = a0[DW-2 -: EXP_W];
    assign eb = b0[DW-2 -: EXP_W];
    assign ma = a0[MAN_W-1:0];
    assign mb = b0[MAN_W-1:0];

    // exponent field zero covers true zeros and subnormals (flushed)
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);

    assign c_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    assign c_inf  = !c_nan && (a_inf || b_inf);
    assign c_zero = !c_nan && !c_inf && (a_zero || b_zero);
    assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    logic                  v1, sign1, nan1, inf1, zero1;
    logic signed [EW2-1:0] e1;
    logic [MAN_W-1:0]      ma1, mb1;

    logic                  v2, sign2, nan2, inf2, zero2;
    logic signed [EW2-1:0] e2;
    logic [PW-1:0]         p2;

    // S3 normalise and round
    logic                  hi, guard, sticky, rup;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        frac_r;
    logic signed [EW2-1:0] e_n, e_r;
    logic [DW-1:0]         res_m;
    logic [3:0]            res_f;

    assign hi     = p2[PW-1];
    assign frac   = hi ? p2[PW-2 -: MAN_W] : p2[PW-3 -: MAN_W];
    assign guard  = hi ? p2[MAN_W] : p2[MAN_W-1];
    assign sticky = hi ? (|p2[MAN_W-1:0]) : (|p2[MAN_W-2:0]);
    assign e_n    = hi ? (e2 + ONE_E) : e2;
    assign rup    = guard && (sticky || frac[0]);
    assign frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rup};
    // a carry out leaves frac_r[MAN_W-1:0] all zero, which is already 1.000 after the shift
    assign e_r    = e_n + $signed({{(EW2-1){1'b0}}, frac_r[MAN_W]});

    always_comb begin
        res_m = {sign2, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        res_f = {3'b000, guard || sticky};
        if (nan2) begin
            res_m = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            res_f = 4'b1000;
        end else if (inf2) begin
            res_m = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f = 4'b0000;
        end else if (zero2) begin
            res_m = {sign2, {(DW-1){1'b0}}};
            res_f = 4'b0000;
        end else if (e_r >= EMAX) begin
            res_m = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f = 4'b0101;
        end else if (e_r <= ZERO_E) begin
            res_m = {sign2, {(DW-1){1'b0}}};
            res_f = 4'b0011;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v0      <= 1'b0;
            a0      <= '0;
            b0      <= '0;
            v1      <= 1'b0;
            sign1   <= 1'b0;
            nan1    <= 1'b0;
            inf1    <= 1'b0;
            zero1   <= 1'b0;
            e1      <= '0;
            ma1     <= '0;
            mb1     <= '0;
            v2      <= 1'b0;
            sign2   <= 1'b0;
            nan2    <= 1'b0;
            inf2    <= 1'b0;
            zero2   <= 1'b0;
            e2      <= '0;
            p2      <= '0;
            o_valid <= 1'b0;
            o_m     <= '0;
            o_flags <= '0;
        end else if (en) begin
            v0      <= i_valid;
            a0      <= i_a;
            b0      <= i_b;
            v1      <= v0;
            sign1   <= a0[DW-1] ^ b0[DW-1];
            nan1    <= c_nan;
            inf1    <= c_inf;
            zero1   <= c_zero;
            e1      <= e_sum;
            ma1     <= ma;
            mb1     <= mb;
            v2      <= v1;
            sign2   <= sign1;
            nan2    <= nan1;
            inf2    <= inf1;
            zero2   <= zero1;
            e2      <= e1;
            p2      <= PW'({1'b1, ma1}) * PW'({1'b1, mb1});
            o_valid <= v2;
            o_m     <= res_m;
            o_flags <= res_f;
        end
    end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Testbench for fpu_mul_pipe: FP32 instance with a scoreboard driven by an
// integer-arithmetic reference model, plus a half-precision instance.
module tb_fpu_mul_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_ready, o_valid;
    logic [31:0] o_m;
    logic [3:0]  o_flags;

    logic        h_valid = 1'b0;
    logic        h_ready = 1'b1;
    logic [15:0] h_a = '0;
    logic [15:0] h_b = '0;
    logic        h_oready, h_ovalid;
    logic [15:0] h_m;
    logic [3:0]  h_flags;

    fpu_mul_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_m(o_m), .o_flags(o_flags)
    );

    fpu_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(h_valid), .o_ready(h_oready), .i_a(h_a), .i_b(h_b),
        .o_valid(h_ovalid), .i_ready(h_ready), .o_m(h_m), .o_flags(h_flags)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] m;
        logic [3:0]  f;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    logic        dir_en = 1'b0;
    logic [31:0] dir_m = '0;
    logic [3:0]  dir_f = '0;
    logic        last_acc = 1'b0;
    logic        saw_block = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: exact integer product of the significands, rounded to
    // nearest-even by comparing the dropped remainder with one half ulp.
    // Returns {flags, result}.
    function automatic logic [35:0] ref_mul(input int ew, input int mw, input longint a, input longint b);
        longint one = 1;
        longint emax = (one << ew) - 1;
        longint mmask = (one << mw) - 1;
        longint bias = (one << (ew - 1)) - 1;
        longint ea = (a >> mw) & emax;
        longint eb = (b >> mw) & emax;
        longint fa = a & mmask;
        longint fb = b & mmask;
        longint sgn = (((a ^ b) >> (ew + mw)) & 1) << (ew + mw);
        longint inf_v = sgn | (emax << mw);
        longint qnan = (emax << mw) | (one << (mw - 1));
        longint p, q, rem, half, e;
        int sh;
        bit an, ai, az, bn, bi, bz, ix;
        an = (ea == emax) && (fa != 0);
        ai = (ea == emax) && (fa == 0);
        az = (ea == 0);
        bn = (eb == emax) && (fb != 0);
        bi = (eb == emax) && (fb == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bz) || (az && bi)) return {4'b1000, 32'(qnan)};
        if (ai || bi) return {4'b0000, 32'(inf_v)};
        if (az || bz) return {4'b0000, 32'(sgn)};
        p = ((one << mw) | fa) * ((one << mw) | fb);
        sh = (p >= (one << (2 * mw + 1))) ? mw + 1 : mw;
        q = p >> sh;
        rem = p - (q << sh);
        half = one << (sh - 1);
        e = ea + eb - bias + longint'(sh - mw);
        ix = (rem != 0);
        if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
        if (q == (one << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= emax) return {4'b0101, 32'(inf_v)};
        if (e <= 0) return {4'b0011, 32'(sgn)};
        return {3'b000, ix, 32'(sgn | (e << mw) | (q & mmask))};
    endfunction

    function automatic logic [31:0] rnd_op(input int ew, input int mw);
        longint one = 1;
        longint emax = (one << ew) - 1;
        longint e, m, s;
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: e = 0;
            1: e = emax;
            2: e = longint'($urandom_range(1, 12));
            3: e = emax - 1 - longint'($urandom_range(0, 12));
            default: e = longint'($urandom_range(1, 32'(emax - 1)));
        endcase
        m = longint'(r) & ((one << mw) - 1);
        if ($urandom_range(0, 5) == 0) m = 0;
        s = longint'(r[31]);
        return 32'((s << (ew + mw)) | (e << mw) | m);
    endfunction

    // One clock cycle: drive, check the output side against the scoreboard,
    // record any accepted operand, advance to just after the next edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
        logic [35:0] r;
        exp_t e;
        i_valid = v;
        i_a = a;
        i_b = b;
        i_ready = rdy;
        #2;
        if (o_valid) begin
            if (sbq.size() == 0) begin
                check_eq("spurious_valid", o_valid, 1'b0);
            end else begin
                check_eq("o_m", o_m, sbq[0].m);
                check_eq("o_flags", o_flags, sbq[0].f);
                if (i_ready) begin
                    sbq.delete(0);
                    n_out++;
                end
            end
        end
        check_eq("o_ready", o_ready, !o_valid || i_ready);
        last_acc = i_valid && o_ready;
        if (i_valid && !o_ready) saw_block = 1'b1;
        if (last_acc) begin
            if (dir_en) begin
                e.m = dir_m;
                e.f = dir_f;
            end else begin
                r = ref_mul(8, 23, longint'(a), longint'(b));
                e.m = r[31:0];
                e.f = r[35:32];
            end
            sbq.push_back(e);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic dir_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] em, input logic [3:0] ef);
        int lat;
        dir_en = 1'b1;
        dir_m = em;
        dir_f = ef;
        cyc(1'b1, a, b, 1'b1);
        dir_en = 1'b0;
        lat = 0;
        while (!o_valid && lat < 10) begin
            cyc(1'b0, '0, '0, 1'b1);
            lat++;
        end
        check_eq("latency", lat, 3);
        cyc(1'b0, '0, '0, 1'b1);
    endtask

    task automatic h_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] em, input logic [3:0] ef);
        check_eq("h_oready", h_oready, 1'b1);
        h_valid = 1'b1;
        h_a = a;
        h_b = b;
        cyc(1'b0, '0, '0, 1'b1);
        h_valid = 1'b0;
        repeat (2) cyc(1'b0, '0, '0, 1'b1);
        check_eq("h_valid_early", h_ovalid, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        check_eq("h_valid", h_ovalid, 1'b1);
        check_eq("h_m", h_m, em);
        check_eq("h_flags", h_flags, ef);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qa[8];
        logic [31:0] qb[8];
        logic [35:0] r;
        logic [15:0] ha, hb;
        int base, sent, stall;

        #1 i_rst_n = 1'b0;
        #1;
        check_eq("rst_o_valid", o_valid, 1'b0);
        check_eq("rst_o_m", o_m, '0);
        check_eq("rst_o_flags", o_flags, '0);
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_eq("idle_o_valid", o_valid, 1'b0);

        dir_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        dir_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
        dir_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        dir_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        dir_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        dir_op(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        dir_op(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);

        // back-to-back stream, no backpressure
        for (int i = 0; i < 8; i++) begin
            qa[i] = rnd_op(8, 23);
            qb[i] = rnd_op(8, 23);
        end
        base = n_out;
        for (int i = 0; i < 12; i++) cyc(i < 8, qa[i % 8], qb[i % 8], 1'b1);
        check_eq("stream_cnt", n_out - base, 8);
        check_eq("stream_sb_empty", sbq.size(), 0);

        // same stream, downstream stalls 5 cycles after the first result
        base = n_out;
        sent = 0;
        stall = -1;
        saw_block = 1'b0;
        for (int c = 0; c < 60 && (n_out - base) < 8; c++) begin
            logic rdy;
            if (stall < 0 && o_valid) stall = 5;
            rdy = (stall <= 0);
            if (stall > 0) stall--;
            cyc(sent < 8, qa[sent % 8], qb[sent % 8], rdy);
            if (last_acc) sent++;
        end
        check_eq("stall_cnt", n_out - base, 8);
        check_eq("stall_blocked", saw_block, 1'b1);
        check_eq("stall_sb_empty", sbq.size(), 0);

        // random traffic with random backpressure
        for (int c = 0; c < 600; c++)
            cyc($urandom_range(0, 3) != 0, rnd_op(8, 23), rnd_op(8, 23), $urandom_range(0, 3) != 0);
        for (int c = 0; c < 12; c++) cyc(1'b0, '0, '0, 1'b1);
        check_eq("drain_sb_empty", sbq.size(), 0);

        // reset with work in flight
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h40400000, 32'h40400000, 1'b1);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst_o_valid", o_valid, 1'b0);
        check_eq("midrst_o_m", o_m, '0);
        sbq.delete();
        @(posedge i_clk);
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        dir_op(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
        repeat (6) cyc(1'b0, '0, '0, 1'b1);

        // half precision
        h_op(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
        h_op(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        for (int i = 0; i < 30; i++) begin
            ha = 16'(rnd_op(5, 10));
            hb = 16'(rnd_op(5, 10));
            r = ref_mul(5, 10, longint'(ha), longint'(hb));
            h_op(ha, hb, r[15:0], r[35:32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_mul_pipe.md
Name: fpu_mul_pipe

Overview:
Parametrised, pipelined IEEE-754 floating-point multiplier with a valid/ready stream interface and exception flags. It is the next generation of the registered FP32 multiplier top. Format width is generic: EXP_W/MAN_W default to single precision, and 5/10 gives half precision. It sits in the FFT butterfly datapath and multiplies samples by twiddles, and it must tolerate downstream backpressure.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa (fraction) width
DW, 1+EXP_W+MAN_W, derived operand/result width; not overridden

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  operand pair valid
o_ready  out  1  block can accept operands this cycle
i_a  in  DW  operand A
i_b  in  DW  operand B
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_m  out  DW  product
o_flags  out  4  {invalid, overflow, underflow, inexact}, aligned with o_m

Behaviour:
- Reset: all pipeline valids=0, o_valid=0, o_m=0, o_flags=0. Reset is async assert and sync-safe deassert via flops only.
- Reset mid-operation discards all in-flight data. No output is produced for operands accepted before reset.
- Pipeline enable en = !o_valid || i_ready. o_ready = en (combinational). An operand is accepted on a rising edge when i_valid && o_ready.
- While en=0, all stages hold. o_m, o_flags and o_valid stay stable until the transfer o_valid && i_ready.
- Latency: operands accepted at edge N give o_valid=1 after edge N+3 when no stall occurs. Throughput is 1 per cycle.
- Bubbles propagate as valid=0. Stage data registers are don't-care when their valid=0.
- S1 (unpack/classify/exponent):
  - sign = a.s ^ b.s.
  - Classify each operand as zero, inf, NaN or normal.
  - Subnormal inputs are flushed to signed zero (FTZ).
  - Biased exponent sum E = ea + eb - bias, computed with EXP_W+2 bits signed. bias = 2^(EXP_W-1)-1.
- S2: significand product P = {1,ma} * {1,mb}, 2*(MAN_W+1) bits unsigned.
- S3 (normalise/round/pack):
  - If P MSB=1, shift right 1 and E+1.
  - Round-to-nearest-even using guard bit plus sticky (OR of the remaining bits). A rounding carry-out renormalises and increments E again.
- Specials, with priority top to bottom:
  - NaN operand, or inf*zero: canonical qNaN {0, all-ones exp, 1, 0...} (0x7FC00000 for FP32). invalid=1.
  - inf * (inf or normal): signed inf.
  - zero * (zero or normal): signed zero, no flags.
  - E >= 2^EXP_W-1 after rounding: signed inf. overflow=1, inexact=1.
  - E <= 0: flush to signed zero (FTZ output). underflow=1, inexact=1.
  - Otherwise normal result. inexact=1 iff guard|sticky.
- No state beyond the pipeline registers. Simultaneous transfer-out and accept-in in the same cycle is legal and keeps full rate.

Test Plan:
- 0x3FC00000*0x40000000, i_ready=1 → after 3 cycles o_m=0x40400000, flags=0000. Also 0xC0000000*0x40400000 → 0xC0C00000.
- 0x3F800001*0x3F800001 → 0x3F800002, flags=0001 (RNE, sticky set). 0x7F7FFFFF*0x40000000 → 0x7F800000, flags=0101.
- 0x7F800000*0x00000000 → 0x7FC00000, flags=1000. 0x00800000*0x3F000000 → 0x00000000, flags=0011. Subnormal 0x00000001*0x40000000 → 0x00000000, flags=0000.
- Stream 8 back-to-back pairs, i_ready=1 → 8 consecutive o_valid cycles in order, starting at cycle 3, no drops.
- Same stream with i_ready held 0 for 5 cycles after the first result → o_ready drops, o_m stable while stalled, all 8 results delivered in order, none duplicated.
- Assert i_rst_n=0 with 3 ops in flight → o_valid=0, o_m=0 immediately. After release, a new op 0x40000000*0x40000000 → 0x40800000 at +3 cycles, with no stale output.
- EXP_W=5, MAN_W=10: 0x3E00*0x4000 → 0x4200; 0x7BFF*0x4000 → 0x7C00 overflow.
